auth_msg_tx_serializer: RTL and testbench

Downstream stage of the authentication driver. Captures the wide authentication message (USB-framed or plain) when the driver raises `auth_msg_ready` and streams it MSB-byte-first over a byte-wide valid/ready interface toward the PHY/transport. After the last byte is accepted, it returns a one-cycle acknowledge that feeds the driver's `Ack_in`, closing the driver's ACK state.

---
 rtl/auth_msg_tx_serializer.sv | 137 +++++++++++++
 tb/tb_auth_msg_tx_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/auth_msg_tx_serializer.sv
// auth_msg_tx_serializer
// Captures a wide authentication message on a rising edge of auth_msg_ready
// and streams it MSB-byte-first over a byte-wide valid/ready link, ending
// with a one-cycle Ack_out. Illegal lengths are rejected with Error_len and
// Ack_out pulsed together, without sending anything.
module auth_msg_tx_serializer #(
  parameter int MSG_BYTES = 264,
  parameter int CNT_W     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   auth_msg_ready,
  input  logic [MSG_BYTES*8-1:0] msg_in,
  input  logic [CNT_W-1:0]       msg_len,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   byte_last,
  output logic                   Ack_out,
  output logic                   busy,
  output logic                   Error_len
);

  localparam int               LP_W   = MSG_BYTES * 8;
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MSG_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rdy_q;
  logic [LP_W-1:0]  r_buf;
  logic [CNT_W-1:0] r_rem;
  logic             r_err;

  logic w_start;
  logic w_len_ok;
  logic w_capture;
  logic w_reject;
  logic w_xfer;

  // Start only on a fresh rising edge seen while idle; rdy_q resets high so
  // a level already asserted at reset release is not mistaken for an edge.
  assign w_start  = (r_state == S_IDLE) && auth_msg_ready && !r_rdy_q;
  assign w_len_ok = (msg_len != '0) && (msg_len <= LP_MAX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and outputs decoded from registered state only.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_reject    = 1'b0;
    w_xfer      = 1'b0;
    byte_valid  = 1'b0;
    byte_last   = 1'b0;
    byte_out    = 8'h00;
    Ack_out     = 1'b0;
    busy        = (r_state != S_IDLE);
    Error_len   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_len_ok) begin
            w_capture   = 1'b1;
            w_state_nxt = S_SEND;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = S_ACK;
          end
        end
      end
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = r_buf[LP_W-1 -: 8];
        byte_last  = (r_rem == LP_ONE);
        w_xfer     = byte_ready;
        if (byte_ready && (r_rem == LP_ONE)) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        Ack_out     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Edge-detect history of auth_msg_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_q <= 1'b1;
    end else begin
      r_rdy_q <= auth_msg_ready;
    end
  end

  // Shift buffer and remaining-byte counter; remaining never drops below 1
  // inside SEND because the transfer at 1 leaves SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf <= '0;
      r_rem <= '0;
    end else if (w_capture) begin
      r_buf <= msg_in;
      r_rem <= msg_len;
    end else if (w_xfer) begin
      r_buf <= r_buf << 8;
      r_rem <= r_rem - LP_ONE;
    end
  end

  // Error_len pulse lines up with the ACK cycle that follows a rejection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

endmodule

// File: tb/tb_auth_msg_tx_serializer.sv
// Self-checking bench for auth_msg_tx_serializer (MSG_BYTES=4, CNT_W=3).
// Expected per-cycle behaviour is derived as a timeline from the message,
// length and ready pattern, then compared cycle by cycle.
module tb_auth_msg_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        auth_msg_ready;
  logic [31:0] msg_in;
  logic [2:0]  msg_len;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        Ack_out;
  logic        busy;
  logic        Error_len;

  int n_checks = 0;
  int n_errors = 0;

  auth_msg_tx_serializer #(.MSG_BYTES(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .auth_msg_ready(auth_msg_ready),
    .msg_in        (msg_in),
    .msg_len       (msg_len),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_last     (byte_last),
    .Ack_out       (Ack_out),
    .busy          (busy),
    .Error_len     (Error_len)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       v;
    logic [7:0] b;
    logic       l;
    logic       a;
    logic       e;
    logic       bsy;
  } exp_t;

  typedef struct {
    logic [31:0] msg;
    logic [2:0]  len;
    logic [15:0] pat;   // bit t = byte_ready in cycle t+1 after start; ones beyond
    string       name;
  } vec_t;

  function automatic exp_t mk(logic v, logic [7:0] b, logic l, logic a, logic e, logic bsy);
    exp_t x;
    x.v = v; x.b = b; x.l = l; x.a = a; x.e = e; x.bsy = bsy;
    return x;
  endfunction

  function automatic logic [7:0] byte_of(logic [31:0] msg, int unsigned k);
    logic [31:0] s;
    s = msg >> (8 * (3 - k));
    return s[7:0];
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {v,byte,last,ack,err,busy}=%h required %h", name, act, exp);
    end
  endtask

  task automatic sample(input string name, input exp_t e);
    exp_t a;
    a = mk(byte_valid, e.v ? byte_out : 8'h00, byte_last, Ack_out, Error_len, busy);
    check(name, a, e);
  endtask

  // One transaction: fresh edge on auth_msg_ready, then the expected timeline.
  // auth_msg_ready is left high afterwards, as the driver would until it reacts.
  task automatic run_txn(input string name, input logic [31:0] msg, input logic [2:0] len,
                         input logic [15:0] pat, input bit rnd);
    exp_t        exp_q[$];
    bit          rq[$];
    int unsigned k;
    int unsigned t;
    bit          r;
    if (len == 0 || len > 4) begin
      exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1));
      rq.push_back(1'b1);
    end else begin
      k = 0;
      t = 0;
      while (k < len) begin
        if (rnd) r = (t >= 30) || ($urandom_range(0, 2) != 0);
        else     r = (t >= 16) ? 1'b1 : pat[t];
        exp_q.push_back(mk(1'b1, byte_of(msg, k), k == len - 1, 1'b0, 1'b0, 1'b1));
        rq.push_back(r);
        if (r) k++;
        t++;
      end
      exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
      rq.push_back(1'b1);
    end
    exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    rq.push_back(1'b1);

    @(negedge clk);
    auth_msg_ready = 1'b0;
    byte_ready     = 1'b0;
    @(negedge clk);
    msg_in         = msg;
    msg_len        = len;
    auth_msg_ready = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      byte_ready = rq[i];
      sample(name, exp_q[i]);
    end
  endtask

  task automatic held_high(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample("held_high_no_retrigger", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'hA1B2C3D4, 3'd4, 16'hFFFF, "basic_send"};
    tbl[1] = '{32'hA1B2C3D4, 3'd3, 16'hFFF4, "backpressure"};
    tbl[2] = '{32'hA1B2C3D4, 3'd0, 16'hFFFF, "len_zero"};
    tbl[3] = '{32'hA1B2C3D4, 3'd5, 16'hFFFF, "len_five"};
    tbl[4] = '{32'h5A000000, 3'd1, 16'hFFFF, "single_byte"};
    tbl[5] = '{32'h01020304, 3'd2, 16'hAAAA, "alt_ready"};

    rst_n          = 1'b0;
    auth_msg_ready = 1'b0;
    msg_in         = '0;
    msg_len        = '0;
    byte_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 sample("reset_state", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    check("reset_byte_out", {5'd0, byte_out}, 13'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].name, tbl[i].msg, tbl[i].len, tbl[i].pat, 1'b0);
      if (i == 0) held_high(20);
    end

    // Reset after B2 has been accepted.
    @(negedge clk);
    auth_msg_ready = 1'b0;
    byte_ready     = 1'b1;
    @(negedge clk);
    msg_in         = 32'hA1B2C3D4;
    msg_len        = 3'd4;
    auth_msg_ready = 1'b1;
    @(negedge clk);
    sample("rst_mid_A1", mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    sample("rst_mid_B2", mk(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    sample("rst_mid_C3", mk(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0;
    #1 sample("rst_mid_async_clear", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    check("rst_mid_byte_out", {5'd0, byte_out}, 13'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample("rst_release_no_restart", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Randomized transactions, lengths include illegal 0 and 5..7.
    for (int i = 0; i < 40; i++) begin
      run_txn("random_txn", $urandom, 3'($urandom_range(0, 7)), 16'h0000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
